multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the datapath enables and mux selects. Produces the 3-bit ALU operation class and 4-bit function field consumed by the ALU control decoder, which then drives the ALU. Memory accesses stall on a single ready handshake.

## Interface
Parameters:
- none

Ports:
- CLK  in  1  system clock; all state changes on the rising edge
- RST_n  in  1  reset; asynchronous, active-low
- opcode  in  7  instruction register bits [6:0]
- funct3  in  3  instruction register bits [14:12]
- funct7_5  in  1  instruction register bit 30
- Zero  in  1  ALU result equals zero (combinational from ALU)
- MemReady  in  1  memory has completed the current access this cycle
- PCWrite  out  1  PC register load enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register and OldPC load enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALU result
- ALUSrcA  out  2  A operand select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
- ALUSrcB  out  2  B operand select: 00 = rs2, 01 = immediate, 10 = constant 4
- RegWrite  out  1  register file write enable
- ALUOp  out  3  ALU class: 000 = R, 001 = branch, 010 = load/store, 011 = I-arith, 100 = add
- ALU_funct  out  4  {qualified funct7_5, funct3}, fed to the ALU control decoder
- Illegal  out  1  one-cycle pulse on an unsupported opcode

## Operation
- Moore FSM. Outputs decode from the state, except that PCWrite and IRWrite are additionally gated by MemReady and Zero as stated below.
- Any output not listed for a state is 0.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=100, ResultSrc=10.
  - IRWrite = PCWrite = MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ALUOp=100, which latches the branch/JAL target into ALUOut.
  - Next state by opcode:
    - 0000011 / 0100011 → MEMADR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 0110111 / 0010111 → UPPER
    - anything else → ILLEGAL
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=010. Goes to MEMREAD if opcode[5]=0, otherwise MEMWRITE.
- MEMREAD: AdrSrc=1. Holds until MemReady=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1. MemWrite stays asserted until MemReady=1, then goes to FETCH.
- EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUOp=000. Goes to ALUWB.
- EXEC_I: ALUSrcA=10, ALUSrcB=01, ALUOp=011. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, ALUOp=001, ResultSrc=00. Goes to FETCH.
  - PCWrite = taken, where taken is decided by funct3:
    - 000 (BEQ) and 001 (BNE): taken = Zero. The BNE ALU operation yields zero when the operands differ.
    - 100 (BLT) and 110 (BLTU): taken = ~Zero.
    - 101 (BGE) and 111 (BGEU): taken = Zero.
    - 010 and 011: taken = 0.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=100, ResultSrc=00, PCWrite=1. The PC loads the target while ALUOut captures OldPC+4. Goes to ALUWB.
- UPPER: ALUSrcA = 11 for LUI (opcode[5]=1) or 01 for AUIPC, ALUSrcB=01, ALUOp=100. Goes to ALUWB.
- ILLEGAL: Illegal=1 for exactly one cycle, no writes. Goes to FETCH.
- ALU_funct:
  - In EXEC_R: {funct7_5, funct3}.
  - In EXEC_I: {funct3==101 ? funct7_5 : 0, funct3}.
  - In MEMADR and BRANCH: {0, funct3}.
  - In all other states: 4'b0000.

## Timing
- Reset:
  - RST_n=0 forces state to FETCH immediately, independent of the clock.
  - While reset is held, PCWrite, IRWrite, MemWrite, RegWrite and Illegal are forced to 0.
  - Other outputs take their FETCH values: ALUOp=100, ALUSrcB=10, ResultSrc=10.
- Reset mid-instruction abandons it. No RegWrite or MemWrite occurs after the asynchronous assertion.
- Cycle counts with MemReady=1 throughout:
  - R-type, I-type, LUI, AUIPC: 4 cycles
  - JAL: 4 cycles
  - branch: 3 cycles
  - load: 5 cycles
  - store: 4 cycles
  - illegal opcode: 3 cycles
- Each cycle of MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs are held stable while stalled.
- MemReady is sampled only in FETCH, MEMREAD and MEMWRITE, and ignored in all other states.
- opcode, funct3 and funct7_5 are sampled only in DECODE and later states. They must be stable from the DECODE cycle until the next FETCH.

## Test plan
- Reset: assert RST_n=0 mid-cycle while in ALUWB → state becomes FETCH immediately and RegWrite=0 immediately. After release with MemReady=1, IRWrite=1 on the first edge.
- SUB:
  - Stimulus: opcode=0110011, funct3=000, funct7_5=1.
  - Expected sequence: FETCH, DECODE, EXEC_R, ALUWB.
  - In EXEC_R: ALUOp=000, ALU_funct=1000.
  - In ALUWB: RegWrite=1 for exactly one cycle.
- Load with wait states:
  - Stimulus: opcode=0000011, MemReady=0 for 3 cycles in MEMREAD.
  - Expected: MEMREAD lasts 4 cycles with AdrSrc=1 held. MEMWB asserts RegWrite=1 and ResultSrc=01. Total 8 cycles.
- Branches:
  - BNE with Zero=1 → PCWrite=1 in BRANCH.
  - BLT with Zero=1 → PCWrite=0.
  - BGEU with Zero=1 → PCWrite=1.
  - Each branch takes 3 cycles.
- JAL: PCWrite=1 in FETCH and in JAL, then RegWrite=1 in ALUWB. LUI: ALUSrcA=11, ALUOp=100.
- Illegal opcode 1111111 → Illegal high for exactly 1 cycle, no RegWrite/MemWrite/PCWrite, then IRWrite on the next FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback.
// Latency: 3-5 cycles per instruction with MemReady=1 (branch/illegal 3, load 5, others 4).
// Backpressure: FETCH, MEMREAD and MEMWRITE hold with outputs stable until MemReady=1.
//
// Ports:
//   CLK, RST_n                  clock, asynchronous active-low reset
//   opcode, funct3, funct7_5    instruction fields, stable from DECODE until the next FETCH
//   Zero, MemReady              ALU zero flag, memory completion handshake
//   PCWrite, IRWrite            PC / IR+OldPC load enables (gated by MemReady or branch outcome)
//   AdrSrc, MemWrite            memory address select and write strobe
//   ResultSrc, ALUSrcA, ALUSrcB datapath mux selects
//   RegWrite                    register file write enable
//   ALUOp, ALU_funct            operation class and qualified function field for the ALU decoder
//   Illegal                     one-cycle pulse on an unsupported opcode
module multicycle_control (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [2:0] ALUOp,
  output logic [3:0] ALU_funct,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_UPPER,
    S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t state;
  logic   taken;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (MemReady) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_R:              state <= S_EXEC_R;
            OP_I:              state <= S_EXEC_I;
            OP_BRANCH:         state <= S_BRANCH;
            OP_JAL:            state <= S_JAL;
            OP_LUI, OP_AUIPC:  state <= S_UPPER;
            default:           state <= S_ILLEGAL;
          endcase
        end
        S_MEMADR:   state <= opcode[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (MemReady) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (MemReady) state <= S_FETCH;
        S_EXEC_R:   state <= S_ALUWB;
        S_EXEC_I:   state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_UPPER:    state <= S_ALUWB;
        S_ILLEGAL:  state <= S_FETCH;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // BNE is evaluated by the ALU so that a zero result means "operands differ",
  // which is why it shares the Zero polarity with BEQ.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000, 3'b001: taken = Zero;
      3'b100, 3'b110: taken = ~Zero;
      3'b101, 3'b111: taken = Zero;
      default:        taken = 1'b0;
    endcase
  end

  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    RegWrite  = 1'b0;
    ALUOp     = 3'b000;
    ALU_funct = 4'b0000;
    Illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ALUOp     = 3'b100;
        ResultSrc = 2'b10;
        // Reset holds the state in FETCH, so the load enables are also
        // qualified by RST_n to keep PC/IR untouched while reset is held.
        PCWrite   = MemReady & RST_n;
        IRWrite   = MemReady & RST_n;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ALUOp   = 3'b100;
      end
      S_MEMADR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ALUOp     = 3'b010;
        ALU_funct = {1'b0, funct3};
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b00;
        ALUOp     = 3'b000;
        ALU_funct = {funct7_5, funct3};
      end
      S_EXEC_I: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ALUOp     = 3'b011;
        // Only SRAI/SRLI use bit 30; for other I-ops it is immediate data.
        ALU_funct = {(funct3 == 3'b101) ? funct7_5 : 1'b0, funct3};
      end
      S_ALUWB: begin
        ResultSrc = 2'b00;
        RegWrite  = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b00;
        ALUOp     = 3'b001;
        ResultSrc = 2'b00;
        ALU_funct = {1'b0, funct3};
        PCWrite   = taken;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ALUOp     = 3'b100;
        ResultSrc = 2'b00;
        PCWrite   = 1'b1;
      end
      S_UPPER: begin
        ALUSrcA = opcode[5] ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01;
        ALUOp   = 3'b100;
      end
      S_ILLEGAL: begin
        Illegal = 1'b1;
      end
      default: begin
        ALUOp = 3'b000;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: table of instructions with expected
// per-instruction cycle counts, enable counts and an execute-cycle snapshot.
// Expected records are queued when an instruction is driven and compared when it retires.
module tb_multicycle_control;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic [6:0] opcode = 7'b0;
  logic [2:0] funct3 = 3'b0;
  logic       funct7_5 = 1'b0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b1;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUOp;
  logic [3:0] ALU_funct;

  always #5 CLK = ~CLK;

  multicycle_control dut (
    .CLK(CLK), .RST_n(RST_n), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .RegWrite(RegWrite), .ALUOp(ALUOp), .ALU_funct(ALU_funct), .Illegal(Illegal)
  );

  // snap = {ALUOp, ALU_funct, ALUSrcA, ALUSrcB, PCWrite} in the first cycle after DECODE
  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       zero;
    int         stall_at;
    int         stall_len;
    int         cycles;
    logic [11:0] snap;
    int         pcw;
    int         regw;
    int         memw;
    int         ill;
    int         adr;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input string name, input logic [6:0] op, input logic [2:0] f3,
                              input logic f7, input logic zero, input int sa, input int sl,
                              input int cyc, input logic [11:0] snap, input int pcw,
                              input int regw, input int memw, input int ill, input int adr);
    vec_t v;
    v.name = name; v.op = op; v.f3 = f3; v.f7 = f7; v.zero = zero;
    v.stall_at = sa; v.stall_len = sl; v.cycles = cyc; v.snap = snap;
    v.pcw = pcw; v.regw = regw; v.memw = memw; v.ill = ill; v.adr = adr;
    return v;
  endfunction

  function automatic logic is_fetch();
    return ResultSrc == 2'b10;
  endfunction

  // Entered mid-cycle (after the falling edge) with the DUT in FETCH.
  task automatic run(input vec_t v);
    int cyc = 0, pcw = 0, regw = 0, memw = 0, ill = 0, adr = 0, snap_at;
    logic seen_nf = 1'b0;
    logic done = 1'b0;
    logic [11:0] snap_act = '0;
    vec_t e;
    opcode = v.op; funct3 = v.f3; funct7_5 = v.f7; Zero = v.zero;
    sb.push_back(v);
    snap_at = (v.stall_at == 1) ? 3 + v.stall_len : 3;
    for (int k = 1; k <= 60 && !done; k++) begin
      MemReady = (v.stall_len > 0 && k >= v.stall_at && k < v.stall_at + v.stall_len) ? 1'b0 : 1'b1;
      #1;
      if (is_fetch() && seen_nf) begin
        done = 1'b1;
      end else begin
        if (!is_fetch()) seen_nf = 1'b1;
        cyc++;
        pcw  += int'(PCWrite);
        regw += int'(RegWrite);
        memw += int'(MemWrite);
        ill  += int'(Illegal);
        adr  += int'(AdrSrc);
        if (k == snap_at) snap_act = {ALUOp, ALU_funct, ALUSrcA, ALUSrcB, PCWrite};
        @(posedge CLK);
        @(negedge CLK);
      end
    end
    MemReady = 1'b1;
    e = sb.pop_front();
    chk({e.name, " retired"}, int'(done), 1);
    chk({e.name, " cycles"}, cyc, e.cycles);
    chk({e.name, " snapshot"}, int'(snap_act), int'(e.snap));
    chk({e.name, " PCWrite count"}, pcw, e.pcw);
    chk({e.name, " RegWrite count"}, regw, e.regw);
    chk({e.name, " MemWrite count"}, memw, e.memw);
    chk({e.name, " Illegal count"}, ill, e.ill);
    chk({e.name, " AdrSrc count"}, adr, e.adr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //        name     op          f3      f7 z  sa sl cyc snap{ALUOp,funct,A,B,PCW}               pcw rw mw il ad
    vecs.push_back(mk("add",   7'b0110011, 3'b000, 0, 0, 0, 0, 4, {3'b000,4'b0000,2'b10,2'b00,1'b0}, 1, 1, 0, 0, 0));
    vecs.push_back(mk("sub",   7'b0110011, 3'b000, 1, 0, 0, 0, 4, {3'b000,4'b1000,2'b10,2'b00,1'b0}, 1, 1, 0, 0, 0));
    vecs.push_back(mk("srai",  7'b0010011, 3'b101, 1, 0, 0, 0, 4, {3'b011,4'b1101,2'b10,2'b01,1'b0}, 1, 1, 0, 0, 0));
    vecs.push_back(mk("addi7", 7'b0010011, 3'b000, 1, 0, 0, 0, 4, {3'b011,4'b0000,2'b10,2'b01,1'b0}, 1, 1, 0, 0, 0));
    vecs.push_back(mk("andi7", 7'b0010011, 3'b111, 1, 0, 0, 0, 4, {3'b011,4'b0111,2'b10,2'b01,1'b0}, 1, 1, 0, 0, 0));
    vecs.push_back(mk("lw",    7'b0000011, 3'b010, 0, 0, 0, 0, 5, {3'b010,4'b0010,2'b10,2'b01,1'b0}, 1, 1, 0, 0, 1));
    vecs.push_back(mk("sw",    7'b0100011, 3'b010, 0, 0, 0, 0, 4, {3'b010,4'b0010,2'b10,2'b01,1'b0}, 1, 0, 1, 0, 1));
    vecs.push_back(mk("bne_z1",7'b1100011, 3'b001, 1, 1, 0, 0, 3, {3'b001,4'b0001,2'b10,2'b00,1'b1}, 2, 0, 0, 0, 0));
    vecs.push_back(mk("blt_z1",7'b1100011, 3'b100, 0, 1, 0, 0, 3, {3'b001,4'b0100,2'b10,2'b00,1'b0}, 1, 0, 0, 0, 0));
    vecs.push_back(mk("bgeu_z1",7'b1100011,3'b111, 0, 1, 0, 0, 3, {3'b001,4'b0111,2'b10,2'b00,1'b1}, 2, 0, 0, 0, 0));
    vecs.push_back(mk("beq_z0",7'b1100011, 3'b000, 0, 0, 0, 0, 3, {3'b001,4'b0000,2'b10,2'b00,1'b0}, 1, 0, 0, 0, 0));
    vecs.push_back(mk("bltu_z0",7'b1100011,3'b110, 0, 0, 0, 0, 3, {3'b001,4'b0110,2'b10,2'b00,1'b1}, 2, 0, 0, 0, 0));
    vecs.push_back(mk("br010", 7'b1100011, 3'b010, 0, 1, 0, 0, 3, {3'b001,4'b0010,2'b10,2'b00,1'b0}, 1, 0, 0, 0, 0));
    vecs.push_back(mk("jal",   7'b1101111, 3'b000, 0, 0, 0, 0, 4, {3'b100,4'b0000,2'b01,2'b10,1'b1}, 2, 1, 0, 0, 0));
    vecs.push_back(mk("lui",   7'b0110111, 3'b000, 0, 0, 0, 0, 4, {3'b100,4'b0000,2'b11,2'b01,1'b0}, 1, 1, 0, 0, 0));
    vecs.push_back(mk("auipc", 7'b0010111, 3'b000, 0, 0, 0, 0, 4, {3'b100,4'b0000,2'b01,2'b01,1'b0}, 1, 1, 0, 0, 0));
    vecs.push_back(mk("illeg", 7'b1111111, 3'b000, 0, 0, 0, 0, 3, {3'b000,4'b0000,2'b00,2'b00,1'b0}, 1, 0, 0, 1, 0));
    vecs.push_back(mk("lw_wait",7'b0000011,3'b010, 0, 0, 4, 3, 8, {3'b010,4'b0010,2'b10,2'b01,1'b0}, 1, 1, 0, 0, 4));
    vecs.push_back(mk("sw_wait",7'b0100011,3'b000, 0, 0, 4, 2, 6, {3'b010,4'b0000,2'b10,2'b01,1'b0}, 1, 0, 3, 0, 3));
    vecs.push_back(mk("add_fstall",7'b0110011,3'b000,0,0, 1, 2, 6, {3'b000,4'b0000,2'b10,2'b00,1'b0}, 1, 1, 0, 0, 0));
    vecs.push_back(mk("add_ignmr",7'b0110011,3'b000,0,0,  2, 3, 4, {3'b000,4'b0000,2'b10,2'b00,1'b0}, 1, 1, 0, 0, 0));

    // Reset held: FETCH selects, no write enables even with MemReady=1.
    MemReady = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst PCWrite", int'(PCWrite), 0);
    chk("rst IRWrite", int'(IRWrite), 0);
    chk("rst RegWrite", int'(RegWrite), 0);
    chk("rst MemWrite", int'(MemWrite), 0);
    chk("rst Illegal", int'(Illegal), 0);
    chk("rst ALUOp", int'(ALUOp), 4);
    chk("rst ALUSrcB", int'(ALUSrcB), 2);
    chk("rst ResultSrc", int'(ResultSrc), 2);
    RST_n = 1'b1;
    #1;
    chk("post-rst IRWrite", int'(IRWrite), 1);
    chk("post-rst PCWrite", int'(PCWrite), 1);

    foreach (vecs[i]) run(vecs[i]);

    // After the illegal opcode the next FETCH loads the IR.
    run(vecs[16]);
    chk("illegal then IRWrite", int'(IRWrite), 1);

    // Asynchronous reset in the middle of ALUWB.
    opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
    #1;
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    #1;
    chk("ALUWB RegWrite before reset", int'(RegWrite), 1);
    #1 RST_n = 1'b0;
    #1;
    chk("async rst RegWrite", int'(RegWrite), 0);
    chk("async rst ResultSrc", int'(ResultSrc), 2);
    chk("async rst ALUSrcB", int'(ALUSrcB), 2);
    chk("async rst ALUOp", int'(ALUOp), 4);
    chk("async rst IRWrite", int'(IRWrite), 0);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("held rst RegWrite", int'(RegWrite), 0);
    chk("held rst PCWrite", int'(PCWrite), 0);
    RST_n = 1'b1;
    #1;
    chk("release IRWrite", int'(IRWrite), 1);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("decode ALUSrcA", int'(ALUSrcA), 1);
    chk("decode ALUSrcB", int'(ALUSrcB), 1);
    chk("decode ALUOp", int'(ALUOp), 4);
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    #1;
    chk("back in FETCH", int'(ResultSrc), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
